// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared types and helpers for the multi-precision add sequencer.
package mpadd_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mpadd_byte_mux.sv
// mpadd_byte_mux: picks operand byte idx and merges the adder sum into result byte idx.
module mpadd_byte_mux
    import mpadd_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic [BYTE_W*WORDS-1:0] a_i,
    input  logic [BYTE_W*WORDS-1:0] b_i,
    input  logic [BYTE_W*WORDS-1:0] sum_i,
    input  logic [clog2(WORDS)-1:0] idx_i,
    input  logic [BYTE_W-1:0]       byte_i,
    output logic [BYTE_W-1:0]       a_byte_o,
    output logic [BYTE_W-1:0]       b_byte_o,
    output logic [BYTE_W*WORDS-1:0] sum_o
);
    assign a_byte_o = a_i[BYTE_W*idx_i +: BYTE_W];
    assign b_byte_o = b_i[BYTE_W*idx_i +: BYTE_W];
    always_comb begin
        sum_o = sum_i;
        sum_o[BYTE_W*idx_i +: BYTE_W] = byte_i;
    end
endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: byte-serial wide adder driving one external 8-bit adder, LSB first.
// Define MPADD_SEQ_SUB_EN to add the in_sub port (A - B - borrow).
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*WORDS-1:0] in_a,
    input  logic [BYTE_W*WORDS-1:0] in_b,
    input  logic                    in_cin,
`ifdef MPADD_SEQ_SUB_EN
    input  logic                    in_sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*WORDS-1:0] out_sum,
    output logic                    out_cout,
    output logic [BYTE_W-1:0]       add_a,
    output logic [BYTE_W-1:0]       add_b,
    output logic                    add_cin,
    input  logic [BYTE_W-1:0]       add_sum,
    input  logic                    add_cout
);
    localparam int IDX_W = clog2(WORDS);
    localparam int W = BYTE_W * WORDS;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d, sum_nxt;
    logic             cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
    logic [BYTE_W-1:0] a_byte, b_byte;
    logic             run, sub;

`ifdef MPADD_SEQ_SUB_EN
    logic sub_q, sub_d;
    assign sub = sub_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sub_q <= 1'b0;
        else     sub_q <= sub_d;
    end
    always_comb begin
        sub_d = sub_q;
        if (state_q == IDLE && in_valid) sub_d = in_sub;
    end
`else
    assign sub = 1'b0;
`endif

    mpadd_byte_mux #(.WORDS(WORDS)) u_mux (
        .a_i      (a_q),
        .b_i      (b_q),
        .sum_i    (sum_q),
        .idx_i    (idx_q),
        .byte_i   (add_sum),
        .a_byte_o (a_byte),
        .b_byte_o (b_byte),
        .sum_o    (sum_nxt)
    );

    assign run       = (state_q == RUN);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    // Subtraction is A + ~B + ~borrow, so inverting B and the byte-0 carry is enough.
    assign add_a   = run ? a_byte : '0;
    assign add_b   = run ? (b_byte ^ {BYTE_W{sub}}) : '0;
    assign add_cin = run & ((idx_q == '0) ? (cin_q ^ sub) : carry_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                cin_d   = in_cin;
                idx_d   = '0;
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            sum_d   = sum_nxt;
            carry_d = add_cout;
            if (idx_q == LAST) begin
                cout_d  = add_cout;
                state_d = DONE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (out_ready) begin
            state_d = IDLE;
        end
    end
endmodule
